// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encodings and frame constants.
// Optional even-parity support is enabled with the UART_TX_PARITY_EN macro.
package uart_tx_buffered_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through output, shared by the UART paths.
// Not affected by UART_TX_PARITY_EN.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             PTR_W      = $clog2(DEPTH);
    localparam int             CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    // A push is refused while full even if a pop frees a slot on the same edge.
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    assign full  = (r_count == FULL_COUNT);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an LSB-first 8N1 serialiser.
// Defining UART_TX_PARITY_EN inserts an even-parity bit, giving 8E1 frames.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int                BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT     = 3'(DATA_BITS - 1);

    uart_state_t          r_state;
    logic [BAUD_W-1:0]    r_baud_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic [DATA_BITS-1:0] w_fifo_dout;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_bit_done;
    logic                 w_pop;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_valid),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (fifo_count)
    );

    assign w_bit_done = (r_baud_cnt == '0);
    // Popping at the end of STOP lets the next frame start with no idle gap.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_done));

    assign wr_ready = !w_fifo_full;
    assign tx       = r_tx;
    assign busy     = (r_state != ST_IDLE) || !w_fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            // The line level trails the state by one clock, so every bit still lasts CLKS_PER_BIT clocks.
            case (r_state)
                ST_START: r_tx <= 1'b0;
                ST_DATA:  r_tx <= r_shift[0];
`ifdef UART_TX_PARITY_EN
                ST_PARITY: r_tx <= r_parity;
`endif
                default:  r_tx <= IDLE_LEVEL;
            endcase

            if ((r_state != ST_IDLE) && !w_bit_done) begin
                r_baud_cnt <= r_baud_cnt - BAUD_W'(1);
            end

            if (w_pop) begin
                r_state    <= ST_START;
                r_baud_cnt <= BAUD_RELOAD;
                r_bit_idx  <= '0;
                r_shift    <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
                r_parity   <= even_parity(w_fifo_dout);
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_START: begin
                        if (w_bit_done) begin
                            r_state    <= ST_DATA;
                            r_baud_cnt <= BAUD_RELOAD;
                            r_bit_idx  <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (w_bit_done) begin
                            r_shift    <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_baud_cnt <= BAUD_RELOAD;
                            if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        if (w_bit_done) begin
                            r_state    <= ST_STOP;
                            r_baud_cnt <= BAUD_RELOAD;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (w_bit_done) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered (CLKS_PER_BIT=4, depth 4) with a loop-back receiver model.
// Build with UART_TX_PARITY_EN defined to exercise the 8E1 frames as well.
module tb_uart_tx_buffered;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME     = 11 * CPB;
    localparam int STOP_SLOT = 10;
`else
    localparam int FRAME     = 10 * CPB;
    localparam int STOP_SLOT = 9;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int base;
    int stray;
    int k;
    logic [7:0] vec3 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    uart_tx_buffered #(
        .CLK_FREQ   (16),
        .BAUD_RATE  (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Loop-back receiver: samples mid-bit on falling edges, independent of the DUT internals.
    logic [7:0] rx_q [$];
    logic [7:0] rx_sh = 8'h00;
    logic       rx_busy = 1'b0;
    int         rx_cnt = 0;
    int         rx_bad = 0;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            rx_busy <= 1'b0;
            rx_cnt  <= 0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % CPB == CPB / 2) begin
                if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) begin
                    rx_sh[rx_cnt / CPB - 1] <= tx;
                end
`ifdef UART_TX_PARITY_EN
                else if (rx_cnt / CPB == 9) begin
                    if (tx !== ^rx_sh) rx_bad <= rx_bad + 1;
                end
`endif
                else if (rx_cnt / CPB == STOP_SLOT) begin
                    if (tx !== 1'b1) rx_bad <= rx_bad + 1;
                    rx_q.push_back(rx_sh);
                    rx_busy <= 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int c);
        int slot;
        slot = c / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Entered at the first sample where tx should be low; leaves one clock past the frame.
    task automatic check_frame(input logic [7:0] b, input bit last);
        for (int c = 0; c < FRAME; c++) begin
            check($sformatf("frame_%02h_c%0d_tx", b, c), {31'd0, tx}, {31'd0, exp_bit(b, c)});
            if (last && c == FRAME - 2) check("busy_before_end", {31'd0, busy}, 32'd1);
            if (last && c == FRAME - 1) check("busy_drop", {31'd0, busy}, 32'd0);
            tick();
        end
    endtask

    task automatic wait_rx(input int n, input int budget);
        int w;
        w = 0;
        while (rx_q.size() < n && w < budget) begin
            tick();
            w++;
        end
        check("rx_count_reached", rx_q.size(), n);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 1000) begin
            tick();
            w++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
        tick();
        tick();
    endtask

    task automatic push1(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        repeat (3) tick();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: single byte latency and waveform
        base = rx_q.size();
        push1(8'hA5);
        check("t1_count_push", {29'd0, fifo_count}, 32'd1);
        check("t1_busy_push", {31'd0, busy}, 32'd1);
        check("t1_tx_idle_n", {31'd0, tx}, 32'd1);
        tick();
        check("t1_count_pop", {29'd0, fifo_count}, 32'd0);
        check("t1_tx_idle_n1", {31'd0, tx}, 32'd1);
        tick();
        check_frame(8'hA5, 1'b1);
        check("t1_tx_after", {31'd0, tx}, 32'd1);
        wait_rx(base + 1, 100);
        check("t1_rx_byte", {24'd0, rx_q[base]}, 32'hA5);
        wait_idle();

        // 2: three consecutive pushes, back-to-back frames
        wr_valid = 1'b1;
        wr_data = 8'h01; tick();
        wr_data = 8'h02; tick();
        wr_data = 8'h03; tick();
        wr_valid = 1'b0;
        check("t2_count_peak", {29'd0, fifo_count}, 32'd2);
        check_frame(8'h01, 1'b0);
        check_frame(8'h02, 1'b0);
        check_frame(8'h03, 1'b1);
        wait_idle();

        // 3: overfill with wr_valid held; refused byte is retried
        base = rx_q.size();
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = vec3[i];
            check($sformatf("t3_ready_push%0d", i), {31'd0, wr_ready}, 32'd1);
            tick();
        end
        check("t3_count_full", {29'd0, fifo_count}, 32'd4);
        check("t3_ready_full", {31'd0, wr_ready}, 32'd0);
        wr_data = vec3[5];
        k = 0;
        while (wr_ready !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        check("t3_ready_returns", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;
        check("t3_count_last", {29'd0, fifo_count}, 32'd4);
        wait_rx(base + 6, 600);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_rx_byte%0d", i), {24'd0, rx_q[base + i]}, {24'd0, vec3[i]});
        end
        wait_idle();
        check("t3_no_extra", rx_q.size(), base + 6);

        // 4a: reset during a low data bit forces tx high without a clock
        base = rx_q.size();
        push1(8'h00);
        tick();
        tick();
        repeat (5) tick();
        check("t4a_tx_low", {31'd0, tx}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("t4a_tx_async", {31'd0, tx}, 32'd1);
        check("t4a_busy_async", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b0;

        // 4b: reset at the third data bit of 0xFF with two bytes queued
        wr_valid = 1'b1;
        wr_data = 8'hFF; tick();
        wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_valid = 1'b0;
        check("t4b_queued", {29'd0, fifo_count}, 32'd2);
        check("t4b_start", {31'd0, tx}, 32'd0);
        repeat (13) tick();
        #2 reset = 1'b1;
        #1;
        check("t4b_tx_async", {31'd0, tx}, 32'd1);
        check("t4b_count_async", {29'd0, fifo_count}, 32'd0);
        check("t4b_busy_async", {31'd0, busy}, 32'd0);
        check("t4b_ready_async", {31'd0, wr_ready}, 32'd1);
        tick();
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) stray++;
        end
        check("t4b_quiet_after", stray, 0);
        check("t4b_no_rx", rx_q.size(), base);

`ifdef UART_TX_PARITY_EN
        // 5/6: even parity bit
        push1(8'h07);
        tick();
        tick();
        check_frame(8'h07, 1'b1);
        wait_idle();
        push1(8'h03);
        tick();
        tick();
        check_frame(8'h03, 1'b1);
        wait_idle();
`endif

        // 7: loop-back of 0x00 and 0xFF
        base = rx_q.size();
        wr_valid = 1'b1;
        wr_data = 8'h00; tick();
        wr_data = 8'hFF; tick();
        wr_valid = 1'b0;
        wait_rx(base + 2, 300);
        check("t7_rx_00", {24'd0, rx_q[base]}, 32'h00);
        check("t7_rx_ff", {24'd0, rx_q[base + 1]}, 32'hFF);
        wait_idle();
        check("rx_framing", rx_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
